cl_axi_master_idle_probe: RTL
=============================

CL_AXI_MASTER_IDLE_PROBE -- requirements
Module: cl_axi_master_idle_probe

Interface
REQ-001 SHALL have parameter ID_W, default 16, AXI ID width used for PROBE_ID and the stray-ID capture.
REQ-002 SHALL have parameter ADDR_W, default 64, probe address width.
REQ-003 SHALL have parameter DATA_W, default 512, captured read-data width.
REQ-004 SHALL have parameter CNT_W, default 16, stray-counter width.
REQ-005 SHALL have parameter PROBE_ID, default all-ones, ARID used by probe reads.
REQ-006 SHALL have parameter TIMEOUT_CYCLES, default 1024, probe R-wait limit.
REQ-007 SHALL have port clk_main_a0, input, 1, sole clock.
REQ-008 SHALL have port rst_main_n, input, 1, synchronous active-low reset.
REQ-009 SHALL have port axi_master_bus, axi_if.master, -, driven AXI master interface.
REQ-010 SHALL have port probe_start, input, 1, single-cycle request to issue one probe read.
REQ-011 SHALL have port probe_addr, input, ADDR_W, probe read address, sampled on an accepted start.
REQ-012 SHALL have port probe_busy, output, 1, high while the FSM is not IDLE.
REQ-013 SHALL have port probe_done, output, 1, one-cycle pulse when the probe R beat is accepted.
REQ-014 SHALL have port probe_rdata, output, DATA_W, last probe read data, held.
REQ-015 SHALL have port probe_rresp, output, 2, last probe RRESP, held.
REQ-016 SHALL have port stray_clr, input, 1, clears stray counters and capture.
REQ-017 SHALL have port stray_b_cnt, output, CNT_W, saturating count of stray B beats.
REQ-018 SHALL have port stray_r_cnt, output, CNT_W, saturating count of stray R beats.
REQ-019 SHALL have port stray_first_id, output, ID_W, ID of the first stray beat since clear.
REQ-020 SHALL have port stray_err, output, 1, sticky flag, high while either counter is non-zero.

Function
REQ-021 SHALL drive awvalid, wvalid, wlast, wstrb, wdata, all AW fields and wid to 0 permanently; the write channels never issue a transaction.
REQ-022 SHALL drive bready=1 and rready=1 permanently, so that no response can stall the slave.
REQ-023 SHALL implement FSM states IDLE, AR and RWAIT: IDLE->AR on probe_start; AR->RWAIT on arvalid&&arready; RWAIT->IDLE on rvalid with rid==PROBE_ID.
REQ-024 SHALL set arvalid to 1 from the first cycle after an accepted probe_start, with araddr=probe_addr, arid=PROBE_ID, arlen=0, arsize=log2(DATA_W/8) and arburst=INCR.
REQ-025 SHALL hold arvalid and all AR fields stable until arready, with no timeout and no withdrawal in AR.
REQ-026 SHALL drive all AR fields to 0 whenever arvalid=0.
REQ-027 SHALL capture rdata and rresp on the accepted probe R beat and pulse probe_done on the following cycle.
REQ-028 SHALL ignore probe_start while probe_busy=1.
REQ-029 SHALL count every B beat as stray.
REQ-030 SHALL count an R beat as stray unless the FSM is in RWAIT and rid==PROBE_ID.
REQ-031 SHALL saturate the stray counters at all-ones.
REQ-032 SHALL capture stray_first_id only on the first stray beat after reset or clear.
REQ-033 SHALL, when B and R stray beats arrive in the same cycle, increment both counters and capture the B ID in stray_first_id.
REQ-034 SHALL, when stray_clr coincides with a stray beat, clear first and then count, giving a result of 1 with the ID captured.

Reset
REQ-035 SHALL, while rst_main_n=0 at a rising clk_main_a0 edge, set the FSM to IDLE and drive arvalid, probe_busy, probe_done, probe_rdata, probe_rresp, both counters, stray_first_id and stray_err to 0.
REQ-036 SHALL, on a reset asserted mid-probe, drop arvalid immediately, so that any R that arrives afterwards counts as stray.

Configuration
REQ-037 SHALL, when CL_AXI_PROBE_TIMEOUT_EN is defined, count cycles in RWAIT and at TIMEOUT_CYCLES return to IDLE, set a sticky probe_timeout output (cleared by the next probe_start) and pulse probe_done with probe_rresp=2'b10.
REQ-038 SHALL, when CL_AXI_PROBE_TIMEOUT_EN is undefined, have no counter and no probe_timeout port, and wait in RWAIT indefinitely.

Structure
REQ-039 SHALL place the FSM state enum, the AXI burst/resp constants and the default PROBE_ID in package cl_axi_probe_pkg.
REQ-040 SHALL implement the stray-tracking logic as sub-module cl_axi_stray_counter, instantiated once for B and once for R, and combine the first-ID capture in the parent.

Verification
REQ-041 SHALL verify idle tie-off: 100 cycles after reset -> awvalid=wvalid=arvalid=0, bready=rready=1 and all counters 0.
REQ-042 SHALL verify a probe with a delayed slave: probe_start with addr 0x1000, arready after 3 cycles, R with rdata=0xA5.., rresp=0 -> exactly one AR, probe_done 1 cycle after R, and probe_rdata matches.
REQ-043 SHALL verify stray injection: B id=0x3, then R id=0x7 -> stray_b_cnt=1, stray_r_cnt=1, stray_first_id=0x3 and stray_err=1.
REQ-044 SHALL verify saturation with CNT_W=4: 20 stray B beats -> stray_b_cnt=15; then stray_clr together with a B beat -> count=1.
REQ-045 SHALL verify timeout with CL_AXI_PROBE_TIMEOUT_EN and TIMEOUT_CYCLES=8, with the slave never answering R -> return to IDLE after 8 cycles in RWAIT, probe_timeout=1 and rresp=2'b10.
REQ-046 SHALL verify reset in RWAIT followed by R id=PROBE_ID -> stray_r_cnt=1 and no probe_done.

Source files
------------

// File: rtl/cl_axi_master_idle_probe_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | cl_axi_probe_pkg                                                         |
// | Shared types and AXI constants for the idle-master probe.                |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
package cl_axi_probe_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_AR    = 2'd1,
    ST_RWAIT = 2'd2
  } probe_state_e;

  localparam logic [1:0] c_burst_incr  = 2'b01;
  localparam logic [1:0] c_resp_slverr = 2'b10;

  // Wide enough for any sensible ID_W; callers slice it to their own width.
  localparam int unsigned c_max_id_w = 64;
  localparam logic [c_max_id_w-1:0] c_default_probe_id = '1;

  function automatic logic [2:0] axi_size_of(input int unsigned data_w);
    return 3'($clog2(data_w / 8));
  endfunction

endpackage
`default_nettype wire

// File: rtl/cl_axi_master_idle_probe_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | axi_if                                                                   |
// | AXI bus bundle with master and slave views.                              |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
interface axi_if #(
  parameter int unsigned ID_W   = 16,
  parameter int unsigned ADDR_W = 64,
  parameter int unsigned DATA_W = 512
) ();

  logic [ID_W-1:0]     awid;
  logic [ADDR_W-1:0]   awaddr;
  logic [7:0]          awlen;
  logic [2:0]          awsize;
  logic [1:0]          awburst;
  logic                awvalid;
  logic                awready;

  logic [ID_W-1:0]     wid;
  logic [DATA_W-1:0]   wdata;
  logic [DATA_W/8-1:0] wstrb;
  logic                wlast;
  logic                wvalid;
  logic                wready;

  logic [ID_W-1:0]     bid;
  logic [1:0]          bresp;
  logic                bvalid;
  logic                bready;

  logic [ID_W-1:0]     arid;
  logic [ADDR_W-1:0]   araddr;
  logic [7:0]          arlen;
  logic [2:0]          arsize;
  logic [1:0]          arburst;
  logic                arvalid;
  logic                arready;

  logic [ID_W-1:0]     rid;
  logic [DATA_W-1:0]   rdata;
  logic [1:0]          rresp;
  logic                rlast;
  logic                rvalid;
  logic                rready;

  modport master (
    output awid, awaddr, awlen, awsize, awburst, awvalid,
    input  awready,
    output wid, wdata, wstrb, wlast, wvalid,
    input  wready,
    input  bid, bresp, bvalid,
    output bready,
    output arid, araddr, arlen, arsize, arburst, arvalid,
    input  arready,
    input  rid, rdata, rresp, rlast, rvalid,
    output rready
  );

  modport slave (
    input  awid, awaddr, awlen, awsize, awburst, awvalid,
    output awready,
    input  wid, wdata, wstrb, wlast, wvalid,
    output wready,
    output bid, bresp, bvalid,
    input  bready,
    input  arid, araddr, arlen, arsize, arburst, arvalid,
    output arready,
    output rid, rdata, rresp, rlast, rvalid,
    input  rready
  );

endinterface
`default_nettype wire

// File: rtl/cl_axi_master_idle_probe_stray_counter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | cl_axi_stray_counter                                                     |
// | Saturating event counter with a clear that still counts its own cycle.   |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module cl_axi_stray_counter #(
  parameter int unsigned CNT_W = 16
) (
  input  wire logic             clk,
  input  wire logic             rst_n,
  input  wire logic             i_clr,
  input  wire logic             i_hit,
  output logic [CNT_W-1:0]      o_cnt
);

  localparam logic [CNT_W-1:0] c_cnt_max = '1;

  logic [CNT_W-1:0] r_cnt;

  // A hit coinciding with clear lands on a freshly zeroed counter.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (i_clr) begin
      r_cnt <= CNT_W'(i_hit);
    end else if (i_hit && (r_cnt != c_cnt_max)) begin
      r_cnt <= r_cnt + CNT_W'(1);
    end
  end

  assign o_cnt = r_cnt;

endmodule
`default_nettype wire

// File: rtl/cl_axi_master_idle_probe.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | cl_axi_master_idle_probe                                                 |
// | Parks an AXI master port idle, issues on-demand single-beat probe reads  |
// | and tallies unexpected B/R beats. Optional R-wait timeout is enabled by  |
// | defining CL_AXI_PROBE_TIMEOUT_EN.                                        |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module cl_axi_master_idle_probe
  import cl_axi_probe_pkg::*;
#(
  parameter int unsigned     ID_W           = 16,
  parameter int unsigned     ADDR_W         = 64,
  parameter int unsigned     DATA_W         = 512,
  parameter int unsigned     CNT_W          = 16,
  parameter logic [ID_W-1:0] PROBE_ID       = c_default_probe_id[ID_W-1:0],
  parameter int unsigned     TIMEOUT_CYCLES = 1024
) (
  input  wire logic              clk_main_a0,
  input  wire logic              rst_main_n,
  axi_if.master                  axi_master_bus,
  input  wire logic              probe_start,
  input  wire logic [ADDR_W-1:0] probe_addr,
  output logic                   probe_busy,
  output logic                   probe_done,
  output logic [DATA_W-1:0]      probe_rdata,
  output logic [1:0]             probe_rresp,
`ifdef CL_AXI_PROBE_TIMEOUT_EN
  output logic                   probe_timeout,
`endif
  input  wire logic              stray_clr,
  output logic [CNT_W-1:0]       stray_b_cnt,
  output logic [CNT_W-1:0]       stray_r_cnt,
  output logic [ID_W-1:0]        stray_first_id,
  output logic                   stray_err
);

  localparam logic [2:0] c_arsize = axi_size_of(DATA_W);

`ifdef CL_AXI_PROBE_TIMEOUT_EN
  localparam int unsigned        c_wait_w    = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [c_wait_w-1:0] c_wait_last = c_wait_w'(TIMEOUT_CYCLES - 1);
  logic [c_wait_w-1:0] r_wait_cnt;
`endif

  probe_state_e      r_state;
  logic              r_arvalid;
  logic [ADDR_W-1:0] r_araddr;
  logic [ID_W-1:0]   r_first_id;

  logic w_probe_hit;
  logic w_b_stray;
  logic w_r_stray;
  logic w_any_stray;
  logic w_unused;

  // Write side is permanently parked; responses are always accepted.
  assign axi_master_bus.awid    = '0;
  assign axi_master_bus.awaddr  = '0;
  assign axi_master_bus.awlen   = '0;
  assign axi_master_bus.awsize  = '0;
  assign axi_master_bus.awburst = '0;
  assign axi_master_bus.awvalid = 1'b0;
  assign axi_master_bus.wid     = '0;
  assign axi_master_bus.wdata   = '0;
  assign axi_master_bus.wstrb   = '0;
  assign axi_master_bus.wlast   = 1'b0;
  assign axi_master_bus.wvalid  = 1'b0;
  assign axi_master_bus.bready  = 1'b1;
  assign axi_master_bus.rready  = 1'b1;

  // AR fields read as zero whenever no request is presented.
  assign axi_master_bus.arvalid = r_arvalid;
  assign axi_master_bus.araddr  = r_araddr;
  assign axi_master_bus.arid    = r_arvalid ? PROBE_ID : '0;
  assign axi_master_bus.arlen   = '0;
  assign axi_master_bus.arsize  = r_arvalid ? c_arsize : 3'b000;
  assign axi_master_bus.arburst = r_arvalid ? c_burst_incr : 2'b00;

  assign w_probe_hit = axi_master_bus.rvalid && (r_state == ST_RWAIT)
                       && (axi_master_bus.rid == PROBE_ID);
  assign w_b_stray   = axi_master_bus.bvalid;
  assign w_r_stray   = axi_master_bus.rvalid && !w_probe_hit;
  assign w_any_stray = w_b_stray || w_r_stray;

  assign w_unused = &{1'b0, axi_master_bus.awready, axi_master_bus.wready,
                      axi_master_bus.bresp, axi_master_bus.rlast
`ifndef CL_AXI_PROBE_TIMEOUT_EN
                      , (TIMEOUT_CYCLES == 0)
`endif
                     };

  always_ff @(posedge clk_main_a0) begin
    if (!rst_main_n) begin
      r_state     <= ST_IDLE;
      r_arvalid   <= 1'b0;
      r_araddr    <= '0;
      probe_busy  <= 1'b0;
      probe_done  <= 1'b0;
      probe_rdata <= '0;
      probe_rresp <= 2'b00;
`ifdef CL_AXI_PROBE_TIMEOUT_EN
      r_wait_cnt    <= '0;
      probe_timeout <= 1'b0;
`endif
    end else begin
      probe_done <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (probe_start) begin
            r_state    <= ST_AR;
            r_arvalid  <= 1'b1;
            r_araddr   <= probe_addr;
            probe_busy <= 1'b1;
`ifdef CL_AXI_PROBE_TIMEOUT_EN
            probe_timeout <= 1'b0;
`endif
          end
        end
        ST_AR: begin
          if (axi_master_bus.arready) begin
            r_state   <= ST_RWAIT;
            r_arvalid <= 1'b0;
            r_araddr  <= '0;
`ifdef CL_AXI_PROBE_TIMEOUT_EN
            r_wait_cnt <= '0;
`endif
          end
        end
        ST_RWAIT: begin
          if (w_probe_hit) begin
            r_state     <= ST_IDLE;
            probe_busy  <= 1'b0;
            probe_done  <= 1'b1;
            probe_rdata <= axi_master_bus.rdata;
            probe_rresp <= axi_master_bus.rresp;
          end
`ifdef CL_AXI_PROBE_TIMEOUT_EN
          // The last waiting cycle gives up and reports a slave error.
          else if (r_wait_cnt == c_wait_last) begin
            r_state       <= ST_IDLE;
            probe_busy    <= 1'b0;
            probe_done    <= 1'b1;
            probe_rresp   <= c_resp_slverr;
            probe_timeout <= 1'b1;
          end else begin
            r_wait_cnt <= r_wait_cnt + c_wait_w'(1);
          end
`endif
        end
        default: begin
          r_state    <= ST_IDLE;
          r_arvalid  <= 1'b0;
          r_araddr   <= '0;
          probe_busy <= 1'b0;
        end
      endcase
    end
  end

  cl_axi_stray_counter #(
    .CNT_W (CNT_W)
  ) u_stray_b (
    .clk   (clk_main_a0),
    .rst_n (rst_main_n),
    .i_clr (stray_clr),
    .i_hit (w_b_stray),
    .o_cnt (stray_b_cnt)
  );

  cl_axi_stray_counter #(
    .CNT_W (CNT_W)
  ) u_stray_r (
    .clk   (clk_main_a0),
    .rst_n (rst_main_n),
    .i_clr (stray_clr),
    .i_hit (w_r_stray),
    .o_cnt (stray_r_cnt)
  );

  // Counters are non-zero exactly when a stray has been seen since clear,
  // so the error flag doubles as the "first ID already captured" marker.
  assign stray_err = (stray_b_cnt != '0) || (stray_r_cnt != '0);

  always_ff @(posedge clk_main_a0) begin
    if (!rst_main_n) begin
      r_first_id <= '0;
    end else if (stray_clr) begin
      r_first_id <= w_b_stray ? axi_master_bus.bid :
                    (w_r_stray ? axi_master_bus.rid : '0);
    end else if (w_any_stray && !stray_err) begin
      r_first_id <= w_b_stray ? axi_master_bus.bid : axi_master_bus.rid;
    end
  end

  assign stray_first_id = r_first_id;

endmodule
`default_nettype wire
